// File: rtl/mult8_iter_4b.sv
// Iterative unsigned multiplier: one 4x4 array multiplier reused over
// all digit pairs, shift-accumulating into a double-width product.

module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    always_comb begin
        o = '0;
        for (int k = 0; k < 4; k++) begin
            o = o + ({4'b0, x & {4{y[k]}}} << k);
        end
    end
endmodule

module mult8_iter_4b #(
    parameter int OPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*OPW-1:0] p,
    output logic             busy
);
    localparam int D  = OPW / 4;
    localparam int K  = D * D;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * OPW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [OPW-1:0]  a_r;
    logic [OPW-1:0]  b_r;
    logic [PW-1:0]   acc;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   di;
    logic [IW-1:0]   dj;
    logic [3:0]      x;
    logic [3:0]      y;
    logic [7:0]      o;
    logic [PW-1:0]   addend;

    // idx walks a-digits fastest, b-digits slowest
    assign di     = idx % IW'(D);
    assign dj     = idx / IW'(D);
    assign x      = 4'(a_r >> (4 * di));
    assign y      = 4'(b_r >> (4 * dj));
    assign addend = PW'(o) << (4 * (di + dj));
    assign p      = acc;

    main u_mul (
        .x(x),
        .y(y),
        .o(o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                    if (idx == IW'(K - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult8_iter_4b.sv
// Directed bench for mult8_iter_4b at OPW=8 and OPW=16.
// Expected products are hand-computed or formed as a*b in the bench.

module tb_mult8_iter_4b;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] p16;
    logic        busy16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult8_iter_4b #(.OPW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    mult8_iter_4b #(.OPW(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .p(p16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one pair, measure latency, check p, then drain.
    task automatic do_op(input string tag, input logic [7:0] va,
                         input logic [7:0] vb, input logic [15:0] exp,
                         input int gap);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~va;
        b = ~vb;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_p"}, 32'(p), 32'(exp));
        repeat (gap) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ovlo"}, 32'(out_valid), 32'd0);
        check({tag, "_irdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        in_valid16 = 1'b0;
        out_ready16 = 1'b0;
        a16 = '0;
        b16 = '0;
        tick();
        tick();
        check("rst_irdy", 32'(in_ready), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_irdy", 32'(in_ready), 32'd1);

        do_op("ffxff", 8'hFF, 8'hFF, 16'hFE01, 0);
        do_op("12x34", 8'h12, 8'h34, 16'h03A8, 1);
        do_op("00xa5", 8'h00, 8'hA5, 16'h0000, 2);

        // backpressure: DONE held, extra in_valid ignored
        a = 8'hC3;
        b = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_busy", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            a = 8'h01;
            b = 8'h01;
            tick();
            check("bp_p", 32'(p), 32'h448E);
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_irdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drain", 32'(out_valid), 32'd0);
        tick();
        check("bp_noacc", 32'(busy), 32'd0);

        // reset at the 2nd RUN cycle discards the operation
        a = 8'h77;
        b = 8'h99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_p", 32'(p), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        tick();
        check("mr_irdy", 32'(in_ready), 32'd1);
        n = 0;
        repeat (8) begin
            tick();
            if (out_valid) n++;
        end
        check("mr_noov", 32'(n), 32'd0);
        do_op("0fxf0", 8'h0F, 8'hF0, 16'h0E10, 0);

        // accept-to-accept period with both handshakes held high
        a = 8'h03;
        b = 8'h05;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
            if (out_valid) check("per_p", 32'(p), 32'd15);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("period", 32'(n + 1), 32'd6);

        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op("rnd", ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)));
        end

        // 16-bit operands: 16 digit products
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 100) begin
            tick();
            n++;
        end
        check("w16_lat", 32'(n), 32'd16);
        check("w16_p0", p16, 32'hFFFE0001);
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        a16 = 16'h1234;
        b16 = 16'h0002;
        in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 100) begin
            tick();
            n++;
        end
        check("w16_p1", p16, 32'h00002468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
